// File: rtl/queue_pkg.sv
// Shared definitions for the byte queue and its serial drain stage.
package queue_pkg;
  localparam int DATA_W      = 8;
  localparam int LEN_W       = 4;
  localparam int QUEUE_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } ser_state_t;
endpackage

// File: rtl/queue_serializer_bit_timer.sv
// Bit-period timer: 8-bit counter that ticks on count B-1, then restarts from zero.
module bit_timer #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk_10khz,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       w_tick;

  assign w_tick = (r_cnt == LAST);
  assign o_tick = w_tick;

  // Wrapping on the tick keeps every bit exactly BIT_CYCLES long.
  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (i_clear || w_tick) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 8'd1;
  end
endmodule

// File: rtl/queue_serializer.sv
// Drains the byte queue one entry at a time and sends each byte as an 8N1 frame, LSB first.
module queue_serializer #(
  parameter int DATA_W              = 8,
  parameter int LEN_W               = 4,
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic              clk_10khz,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic              tx_out,
  output logic              busy_out,
  output logic [7:0]        sent_count_out
);
  import queue_pkg::*;

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit;
  logic              r_deq;
  logic              r_tx;
  logic              r_busy;
  logic [7:0]        r_sent;
  logic              w_tick;
  logic              w_clear;

  // The timer only runs while a bit is on the line; it sits at zero otherwise.
  assign w_clear = (r_state == IDLE) || (r_state == REQ) || (r_state == WAIT);

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk_10khz (clk_10khz),
    .reset     (reset),
    .i_clear   (w_clear),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_deq   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_sent  <= 8'd0;
    end else begin
      r_deq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable_in && (len_in != '0)) begin
            r_state <= REQ;
            r_deq   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        REQ: r_state <= WAIT;
        // The queue's data_out settled during WAIT, so it is safe to capture now.
        WAIT: begin
          r_shift <= data_in;
          r_tx    <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_sent  <= r_sent + 8'd1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dequeue_out    = r_deq;
  assign tx_out         = r_tx;
  assign busy_out       = r_busy;
  assign sent_count_out = r_sent;
endmodule
